// File: rtl/la_pwrseq_pkg.sv
// Shared definitions for the power-switch sequencer: FSM encoding and width helpers.
package la_pwrseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_REL  = 2'd2,
        ST_DOWN = 2'd3
    } pwrseq_state_t;

    // Down-counter width able to hold DLY itself.
    function automatic int cnt_width(input int dly);
        return (dly < 1) ? 1 : $clog2(dly + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/la_rrarb.sv
// N-way round-robin arbiter: combinational grant of the first request at or after
// the pointer, pointer moves past the winner when the grant is taken.
module la_rrarb
    import la_pwrseq_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
)(
    input  logic          clk,
    input  logic          nreset,
    input  logic [N-1:0]  i_req,
    input  logic          i_take,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] r_ptr;
    int            w_dist;
    int            w_best;

    // The winner is the requester with the smallest circular distance from the pointer.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_best  = N;
        w_dist  = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + N - int'(r_ptr)) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = IW'(j);
                o_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ptr <= '0;
        end else if (i_take && o_valid) begin
            r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + IW'(1);
        end
    end

endmodule

// File: rtl/la_pwrseq.sv
// Power-switch sequencer for N gated domains: staggers header stages, then releases
// isolation and domain reset; power-off isolates first and drops all stages together.
//
//  state | meaning
//  IDLE  | pick next pending domain (round-robin), start its up or down sequence
//  UP    | stage enables staggered by DLY; one extra DLY, then isolation released
//  REL   | domain reset released and ack raised
//  DOWN  | all stage enables of the domain cleared together
module la_pwrseq
    import la_pwrseq_pkg::*;
#(
    parameter int    N      = 4,
    parameter int    STAGES = 2,
    parameter int    DLY    = 8,
    parameter string PROP   = "DEFAULT"
)(
    input  logic                clk,
    input  logic                nreset,
    input  logic [N-1:0]        on_req,
    output logic [N*STAGES-1:0] pwr_en,
    output logic [N-1:0]        iso,
    output logic [N-1:0]        dom_nreset,
    output logic [N-1:0]        on_ack,
    output logic                busy
);

    localparam int IW = idx_width(N);
    localparam int SW = idx_width(STAGES);
    localparam int CW = cnt_width(DLY);
    localparam int NS = N * STAGES;

    if (N < 1 || STAGES < 1 || DLY < 1 || PROP == "") begin : g_bad_param
        $error("la_pwrseq: invalid parameter set");
    end

    pwrseq_state_t r_state;
    logic [IW-1:0] r_dom;
    logic [SW-1:0] r_stage;
    logic [CW-1:0] r_cnt;
    logic [NS-1:0] r_pwr_en;
    logic [N-1:0]  r_iso;
    logic [N-1:0]  r_dom_nreset;
    logic [N-1:0]  r_on_ack;
    logic          r_busy;

    logic [N-1:0]  w_pending;
    logic [N-1:0]  w_gnt_oh;
    logic [N-1:0]  w_dom_oh;
    logic [NS-1:0] w_gnt_bit;
    logic [NS-1:0] w_next_bit;
    logic [NS-1:0] w_dom_mask;
    logic [IW-1:0] w_gnt_idx;
    logic          w_gnt_valid;
    logic          w_gnt_on;
    logic          w_take;
    logic          w_cnt_tc;
    logic          w_last_stage;

    assign w_pending    = on_req ^ r_on_ack;
    assign w_take       = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_gnt_on     = |(on_req & w_gnt_oh);
    assign w_cnt_tc     = (r_cnt == CW'(1));
    assign w_last_stage = (int'(r_stage) == STAGES - 1);

    la_rrarb #(.N(N), .IW(IW)) u_arb (
        .clk     (clk),
        .nreset  (nreset),
        .i_req   (w_pending),
        .i_take  (w_take),
        .o_valid (w_gnt_valid),
        .o_idx   (w_gnt_idx)
    );

    // One-hot views of the granted and the active domain, expanded to stage bits.
    always_comb begin
        w_gnt_oh   = '0;
        w_dom_oh   = '0;
        w_gnt_bit  = '0;
        w_next_bit = '0;
        w_dom_mask = '0;
        for (int d = 0; d < N; d++) begin
            w_gnt_oh[d] = (int'(w_gnt_idx) == d);
            w_dom_oh[d] = (int'(r_dom) == d);
            for (int k = 0; k < STAGES; k++) begin
                w_gnt_bit[d*STAGES + k]  = (int'(w_gnt_idx) == d) && (k == 0);
                w_next_bit[d*STAGES + k] = (int'(r_dom) == d) && (k == int'(r_stage) + 1);
                w_dom_mask[d*STAGES + k] = (int'(r_dom) == d);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_dom        <= '0;
            r_stage      <= '0;
            r_cnt        <= '0;
            r_pwr_en     <= '0;
            r_iso        <= '1;
            r_dom_nreset <= '0;
            r_on_ack     <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_dom  <= w_gnt_idx;
                        r_busy <= 1'b1;
                        if (w_gnt_on) begin
                            r_pwr_en <= r_pwr_en | w_gnt_bit;
                            r_stage  <= '0;
                            r_cnt    <= CW'(DLY);
                            r_state  <= ST_UP;
                        end else begin
                            r_on_ack     <= r_on_ack & ~w_gnt_oh;
                            r_dom_nreset <= r_dom_nreset & ~w_gnt_oh;
                            r_iso        <= r_iso | w_gnt_oh;
                            r_state      <= ST_DOWN;
                        end
                    end
                end
                ST_UP: begin
                    if (!w_cnt_tc) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (!w_last_stage) begin
                        r_stage  <= r_stage + SW'(1);
                        r_pwr_en <= r_pwr_en | w_next_bit;
                        r_cnt    <= CW'(DLY);
                    end else begin
                        r_cnt   <= '0;
                        r_iso   <= r_iso & ~w_dom_oh;
                        r_state <= ST_REL;
                    end
                end
                ST_REL: begin
                    r_dom_nreset <= r_dom_nreset | w_dom_oh;
                    r_on_ack     <= r_on_ack | w_dom_oh;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                ST_DOWN: begin
                    r_pwr_en <= r_pwr_en & ~w_dom_mask;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pwr_en     = r_pwr_en;
    assign iso        = r_iso;
    assign dom_nreset = r_dom_nreset;
    assign on_ack     = r_on_ack;
    assign busy       = r_busy;

endmodule

// File: tb/tb_la_pwrseq.sv
// Self-checking bench for la_pwrseq: directed latency checks plus randomized requests
// compared against a timeline model of the sequencing rules.
module tb_la_pwrseq;

    localparam int N   = 4;
    localparam int S   = 2;
    localparam int DLY = 8;
    localparam int NS  = N * S;
    localparam logic [20:0] RST_VAL = {8'h00, 4'hF, 4'h0, 4'h0, 1'b0};

    logic          clk = 1'b0;
    logic          nreset;
    logic [N-1:0]  on_req;
    logic [NS-1:0] pwr_en;
    logic [N-1:0]  iso;
    logic [N-1:0]  dom_nreset;
    logic [N-1:0]  on_ack;
    logic          busy;

    int tests = 0;
    int fails = 0;

    la_pwrseq #(.N(N), .STAGES(S), .DLY(DLY), .PROP("DEFAULT")) dut (
        .clk        (clk),
        .nreset     (nreset),
        .on_req     (on_req),
        .pwr_en     (pwr_en),
        .iso        (iso),
        .dom_nreset (dom_nreset),
        .on_ack     (on_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Timeline model: a job started at edge t0 produces its events at fixed offsets.
    logic [NS-1:0] m_pwr;
    logic [N-1:0]  m_iso, m_nrst, m_ack;
    logic          m_busy;
    int            m_ptr, m_t, m_t0, m_dom;
    bit            m_job, m_on;

    always @(posedge clk or negedge nreset) begin : model
        int pick;
        if (!nreset) begin
            m_pwr = '0; m_iso = '1; m_nrst = '0; m_ack = '0; m_busy = 1'b0;
            m_ptr = 0; m_t = 0; m_t0 = 0; m_dom = 0; m_job = 0; m_on = 0;
        end else begin
            m_t++;
            if (!m_job) begin
                pick = -1;
                for (int i = 0; i < N; i++)
                    if (pick < 0 && on_req[(m_ptr + i) % N] !== m_ack[(m_ptr + i) % N])
                        pick = (m_ptr + i) % N;
                if (pick >= 0) begin
                    m_job = 1; m_dom = pick; m_on = on_req[pick]; m_t0 = m_t;
                    m_ptr = (pick + 1) % N; m_busy = 1'b1;
                    if (m_on) m_pwr[pick*S] = 1'b1;
                    else begin
                        m_ack[pick] = 1'b0; m_nrst[pick] = 1'b0; m_iso[pick] = 1'b1;
                    end
                end
            end else if (m_on) begin
                for (int k = 1; k < S; k++)
                    if (m_t == m_t0 + k*DLY) m_pwr[m_dom*S + k] = 1'b1;
                if (m_t == m_t0 + S*DLY) m_iso[m_dom] = 1'b0;
                if (m_t == m_t0 + S*DLY + 1) begin
                    m_ack[m_dom] = 1'b1; m_nrst[m_dom] = 1'b1; m_busy = 1'b0; m_job = 0;
                end
            end else if (m_t == m_t0 + 1) begin
                for (int k = 0; k < S; k++) m_pwr[m_dom*S + k] = 1'b0;
                m_busy = 1'b0; m_job = 0;
            end
        end
    end

    wire [20:0] w_obs = {pwr_en, iso, dom_nreset, on_ack, busy};
    wire [20:0] w_exp = {m_pwr, m_iso, m_nrst, m_ack, m_busy};

    task automatic reset_dut();
        nreset = 1'b0;
        on_req = '0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        on_req = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (w_obs !== RST_VAL) begin
            fails++;
            $display("FAIL reset_asserted: got %h expected %h", w_obs, RST_VAL);
        end
        nreset = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            tests++;
            if (w_obs !== RST_VAL) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", c, w_obs, RST_VAL);
            end
        end
    endtask

    task automatic test_power_on();
        logic [20:0] exp;
        on_req = 4'b0001;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            exp = {6'b0, (j >= 8), 1'b1, 3'b111, (j < 16), 3'b0, (j >= 17), 3'b0, (j >= 17), (j < 17)};
            tests++;
            if (w_obs !== exp) begin
                fails++;
                $display("FAIL power_on E0+%0d: got %h expected %h", j, w_obs, exp);
            end
        end
    endtask

    task automatic test_power_off();
        logic [20:0] exp;
        on_req = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            exp = (j == 0) ? {8'h03, 4'hF, 4'h0, 4'h0, 1'b1} : RST_VAL;
            tests++;
            if (w_obs !== exp) begin
                fails++;
                $display("FAIL power_off E0+%0d: got %h expected %h", j, w_obs, exp);
            end
        end
    endtask

    task automatic test_rr_order();
        int ntrans;
        reset_dut();
        on_req = 4'b1010;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            tests++;
            if (w_obs !== w_exp) begin
                fails++;
                $display("FAIL rr_model E0+%0d: got %h expected %h", j, w_obs, w_exp);
            end
            ntrans = 0;
            for (int d = 0; d < N; d++)
                if (pwr_en[d*S +: S] != '0 && !on_ack[d]) ntrans++;
            if (ntrans > 1) begin
                tests++; fails++;
                $display("FAIL rr_single_transition E0+%0d: got %0d domains expected at most 1", j, ntrans);
            end
            if (j == 17) begin
                tests++;
                if (on_ack !== 4'b0010) begin
                    fails++;
                    $display("FAIL rr_first_ack: got %b expected 0010", on_ack);
                end
            end
            if (j == 18) begin
                tests++;
                if (pwr_en !== 8'h4C) begin
                    fails++;
                    $display("FAIL rr_second_start: got %h expected 4c", pwr_en);
                end
            end
            if (j == 35) begin
                tests++;
                if (on_ack !== 4'b1010) begin
                    fails++;
                    $display("FAIL rr_second_ack: got %b expected 1010", on_ack);
                end
            end
        end
    endtask

    task automatic test_drop_mid_up();
        reset_dut();
        on_req = 4'b0100;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            tests++;
            if (w_obs !== w_exp) begin
                fails++;
                $display("FAIL drop_model E0+%0d: got %h expected %h", j, w_obs, w_exp);
            end
            if (j == 4) on_req = 4'b0000;
            if (j == 17 || j == 18) begin
                tests++;
                if (on_ack[2] !== (j == 17)) begin
                    fails++;
                    $display("FAIL drop_ack E0+%0d: got %b expected %b", j, on_ack[2], (j == 17));
                end
            end
            if (j == 19) begin
                tests++;
                if (pwr_en !== 8'h00) begin
                    fails++;
                    $display("FAIL drop_stages_off: got %h expected 00", pwr_en);
                end
            end
        end
    endtask

    task automatic test_nreset_mid_up();
        reset_dut();
        on_req = 4'b0001;
        repeat (5) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        tests++;
        if (w_obs !== RST_VAL) begin
            fails++;
            $display("FAIL nreset_async: got %h expected %h", w_obs, RST_VAL);
        end
        @(negedge clk);
        nreset = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            tests++;
            if (w_obs !== w_exp) begin
                fails++;
                $display("FAIL nreset_rerun_model E0+%0d: got %h expected %h", j, w_obs, w_exp);
            end
            if (j == 0 || j == 8) begin
                tests++;
                if (pwr_en !== ((j == 0) ? 8'h01 : 8'h03)) begin
                    fails++;
                    $display("FAIL nreset_rerun_stage E0+%0d: got %h", j, pwr_en);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            tests++;
            if (w_obs !== w_exp) begin
                fails++;
                $display("FAIL random_model cycle %0d: got %h expected %h", c, w_obs, w_exp);
            end
            if ((dom_nreset & iso) != '0) begin
                tests++; fails++;
                $display("FAIL random_nreset_iso cycle %0d: got nreset %b iso %b", c, dom_nreset, iso);
            end
            if (c < 700 && $urandom_range(0, 9) == 0)
                on_req[$urandom_range(0, N-1)] ^= 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        on_req = '0;
        test_reset();
        test_power_on();
        test_power_off();
        test_rr_order();
        test_drop_mid_up();
        test_nreset_mid_up();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
